// File: rtl/mul_accum_pkg.sv
// mul_accum_pkg: shared types and constants for the multiply-accumulate stage.
//   state_e     - accumulator FSM states
//   DEF_DATA_W  - default product/accumulator width
//   DEF_CNT_W   - default length/counter width
//   SAT_MAX/MIN - 16-bit signed saturation limits
package mul_accum_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_CNT_W  = 8;

    localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [15:0] SAT_MIN = 16'sh8000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mul_accum_sat_add.sv
// sat_add: combinational signed saturating adder, shared with the ALU add path.
//   a, b  in  DATA_W  signed operands
//   sum   out DATA_W  a+b clamped to the signed DATA_W range
//   sat   out 1       clamping occurred
module sat_add #(
    parameter int DATA_W = 16
) (
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [DATA_W-1:0] sum,
    output logic                     sat
);

    localparam logic signed [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};

    logic signed [DATA_W:0] full;

    always_comb begin
        full = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        sum  = full[DATA_W-1:0];
        sat  = 1'b0;
        // The extra sign bit disagreeing with the DATA_W sign bit means the
        // true sum left the representable range; the top bit tells which way.
        if (full[DATA_W] != full[DATA_W-1]) begin
            sat = 1'b1;
            sum = full[DATA_W] ? MIN_V : MAX_V;
        end
    end

endmodule

// File: rtl/mul_accum.sv
// mul_accum: sums a programmed number of alu_mul products into a saturating
// signed accumulator and returns one result with a sticky overflow flag.
//   clk, rst                 clock, synchronous active-high reset
//   start, len               launch a run of len products (sampled in IDLE)
//   prod_valid/prod_ready    product handshake; prod, prod_ovf payload
//   res_valid/res_ready      result handshake; res, res_ovf payload
//   busy                     run in progress or result pending
module mul_accum
    import mul_accum_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [CNT_W-1:0]         len,
    input  logic                     prod_valid,
    output logic                     prod_ready,
    input  logic signed [DATA_W-1:0] prod,
    input  logic                     prod_ovf,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic signed [DATA_W-1:0] res,
    output logic                     res_ovf,
    output logic                     busy
);

    state_e                   state_q, state_d;
    logic signed [DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     ovf_q, ovf_d;

    logic signed [DATA_W-1:0] add_sum;
    logic                     add_sat;

    sat_add #(.DATA_W(DATA_W)) u_sat_add (
        .a   (acc_q),
        .b   (prod),
        .sum (add_sum),
        .sat (add_sat)
    );

    // Handshake outputs depend on state only, never on inputs.
    assign prod_ready = (state_q == ACC);
    assign res_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign res        = acc_q;
    assign res_ovf    = ovf_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = len;
                    state_d = (len == '0) ? DONE : ACC;
                end
            end
            ACC: begin
                if (prod_valid) begin
                    // prod is summed even when flagged; the flag is only recorded.
                    acc_d = add_sum;
                    ovf_d = ovf_q | prod_ovf | add_sat;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_mul_accum.sv
// tb_mul_accum: directed plus randomized runs against an integer-arithmetic
// model of the accumulate/clamp rules.
module tb_mul_accum;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [7:0]         len;
    logic               prod_valid;
    logic               prod_ready;
    logic signed [15:0] prod;
    logic               prod_ovf;
    logic               res_valid;
    logic               res_ready;
    logic signed [15:0] res;
    logic               res_ovf;
    logic               busy;

    int checks = 0;
    int errors = 0;

    // Stimulus for one run: product value, its overflow flag, bubble-before flag.
    int p_q[$];
    bit o_q[$];
    bit b_q[$];

    mul_accum #(.DATA_W(16), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .prod       (prod),
        .prod_ovf   (prod_ovf),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res        (res),
        .res_ovf    (res_ovf),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ":prod_ready"}, {31'b0, prod_ready}, 32'd0);
        chk({tag, ":res_valid"},  {31'b0, res_valid},  32'd0);
        chk({tag, ":busy"},       {31'b0, busy},       32'd0);
    endtask

    // Runs the queued products through one accumulation and checks the result
    // against plain integer summation with clamping.
    task automatic run(input string tag);
        int  n;
        int  acc;
        bit  ovf;
        n   = p_q.size();
        acc = 0;
        ovf = 1'b0;
        start = 1'b1;
        len   = 8'(n);
        step();
        start = 1'b0;
        chk({tag, ":busy"}, {31'b0, busy}, 32'd1);
        chk({tag, ":ready_after_start"}, {31'b0, prod_ready}, (n != 0) ? 32'd1 : 32'd0);
        for (int i = 0; i < n; i++) begin
            if (b_q[i]) begin
                prod_valid = 1'b0;
                step();
                chk({tag, ":bubble_ready"}, {31'b0, prod_ready}, 32'd1);
                chk({tag, ":bubble_valid"}, {31'b0, res_valid},  32'd0);
            end
            prod_valid = 1'b1;
            prod       = 16'(p_q[i]);
            prod_ovf   = o_q[i];
            acc = acc + p_q[i];
            ovf = ovf | o_q[i];
            if (acc > 32767)  begin acc = 32767;  ovf = 1'b1; end
            if (acc < -32768) begin acc = -32768; ovf = 1'b1; end
            step();
            prod_valid = 1'b0;
            prod_ovf   = 1'b0;
            chk({tag, ":res_valid_timing"}, {31'b0, res_valid}, (i == n - 1) ? 32'd1 : 32'd0);
        end
        chk({tag, ":res"},     {16'b0, res},     {16'b0, 16'(acc)});
        chk({tag, ":res_ovf"}, {31'b0, res_ovf}, {31'b0, ovf});
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk_idle({tag, ":after"});
        p_q.delete();
        o_q.delete();
        b_q.delete();
    endtask

    task automatic push(input int p, input bit o, input bit b);
        p_q.push_back(p);
        o_q.push_back(o);
        b_q.push_back(b);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; prod_valid = 1'b0;
        prod = '0; prod_ovf = 1'b0; res_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        chk_idle("reset");
        chk("reset:res",     {16'b0, res},     32'd0);
        chk("reset:res_ovf", {31'b0, res_ovf}, 32'd0);

        // Sum with bubbles between products.
        push(100, 0, 1); push(200, 0, 1); push(-50, 0, 1);
        run("bubbles");

        push(30000, 0, 0); push(10000, 0, 0);
        run("pos_sat");

        push(-30000, 0, 0); push(-10000, 0, 0);
        run("neg_sat");

        push(5, 1, 0); push(7, 0, 0);
        run("prod_ovf");

        // Saturate then recover within range: clamp happens per step.
        push(32767, 0, 0); push(100, 0, 0); push(-200, 0, 0);
        run("sat_then_back");

        // Zero length, then hold the result under backpressure.
        start = 1'b1; len = 8'd0;
        step();
        start = 1'b0;
        chk("zero:res_valid", {31'b0, res_valid}, 32'd1);
        chk("zero:res",       {16'b0, res},       32'd0);
        chk("zero:res_ovf",   {31'b0, res_ovf},   32'd0);
        for (int i = 0; i < 5; i++) begin
            start = 1'b1; len = 8'd3; prod_valid = 1'b1; prod = 16'sd1234;
            step();
            chk("hold:res_valid",  {31'b0, res_valid},  32'd1);
            chk("hold:res",        {16'b0, res},        32'd0);
            chk("hold:prod_ready", {31'b0, prod_ready}, 32'd0);
        end
        start = 1'b0; prod_valid = 1'b0; res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk_idle("release");

        // Reset mid-run, with an accept coinciding with reset.
        start = 1'b1; len = 8'd3;
        step();
        start = 1'b0; prod_valid = 1'b1; prod = 16'sd50;
        step();
        rst = 1'b1; prod = 16'sd77;
        step();
        rst = 1'b0; prod_valid = 1'b0;
        chk_idle("midrst");
        chk("midrst:res",     {16'b0, res},     32'd0);
        chk("midrst:res_ovf", {31'b0, res_ovf}, 32'd0);
        push(9, 0, 0);
        run("after_rst");

        // A start coinciding with reset is discarded.
        rst = 1'b1; start = 1'b1; len = 8'd2;
        step();
        rst = 1'b0; start = 1'b0;
        chk_idle("start_in_rst");

        // Randomized runs; large magnitudes make saturation likely.
        for (int r = 0; r < 12; r++) begin
            int n;
            n = int'($urandom_range(1, 6));
            for (int i = 0; i < n; i++) begin
                int v;
                if ($urandom_range(0, 1) == 0) v = int'($urandom_range(0, 65535)) - 32768;
                else                           v = int'($urandom_range(0, 400)) - 200;
                push(v, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
            end
            run("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_accum.md
# mul_accum

Multiply-accumulate stage directly downstream of the combinational `alu_mul` signed 16-bit multiplier. It consumes a stream of `alu_mul` products (`dout`) and overflow flags (`ovf`) over a valid/ready handshake. It sums a programmed number of them into a saturating signed accumulator and presents one result with a sticky overflow flag over a second valid/ready handshake. It serves dot-product and running-sum sequences in the ALU datapath.

## Interface
- `DATA_W`, 16, product/accumulator width (two's complement)
- `CNT_W`, 8, width of the length field and the product counter
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `start`  in  1  begin a new accumulation; sampled only in IDLE
- `len`  in  CNT_W  number of products to accumulate; sampled with `start`
- `prod_valid`  in  1  product available (from `alu_mul` issue logic)
- `prod_ready`  out  1  stage accepts a product this cycle
- `prod`  in  DATA_W  signed product (`alu_mul.dout`)
- `prod_ovf`  in  1  product overflowed (`alu_mul.ovf`)
- `res_valid`  out  1  result available
- `res_ready`  in  1  consumer takes result
- `res`  out  DATA_W  signed accumulated result
- `res_ovf`  out  1  sticky: any product overflow or any accumulator saturation in this run
- `busy`  out  1  high in ACC or DONE

## Operation
- States: IDLE, ACC, DONE.
- IDLE: `start`=1 clears acc to 0, clears `res_ovf`, and loads count = `len`.
  - `len`≠0 -> ACC.
  - `len`=0 -> DONE with `res`=0, `res_ovf`=0.
- ACC: `prod_ready`=1. Accept = `prod_valid` & `prod_ready`. Each accept:
  - acc <= sat(acc + prod)
  - `res_ovf` |= `prod_ovf` | saturated
  - count decrements
  - The accept that takes count from 1 to 0 moves to DONE.
  - Cycles without `prod_valid` are bubbles: no state change.
- DONE: `res_valid`=1 and `res` = acc. Both hold stable until `res_ready`=1. On that cycle -> IDLE.
- `start` outside IDLE is ignored; `len` is not re-sampled.
- Arithmetic:
  - Sign-extend both operands to DATA_W+1 and add.
  - Sum > 32767 -> 32767, saturated=1.
  - Sum < −32768 -> −32768, saturated=1.
  - Otherwise truncate to DATA_W.
  - `prod` is summed even when `prod_ovf`=1; the flag only sets `res_ovf`.
- Count is unsigned. Maximum run = 2^CNT_W−1 products.

## Timing
- `prod_ready`, `res_valid`, `busy`: decoded from state registers only, with no combinational path from any input.
- `res`, `res_ovf`: driven directly from registers.
- Latency:
  - `start` accepted at edge N -> ACC (`prod_ready`=1) from cycle N+1.
  - Final product accepted at edge M -> `res_valid`=1 from cycle M+1.
  - `res_ready` at edge K -> IDLE from K+1; a `start` is accepted no earlier than edge K+1.
- Minimum run: 1 + len + 1 cycles with no bubbles and `res_ready` tied high.
- Reset values: state IDLE, acc 0, count 0, `prod_ready` 0, `res_valid` 0, `res` 0, `res_ovf` 0, `busy` 0.
- `rst` mid-run aborts with no result. A `start` or accept coinciding with `rst` is discarded.

## Structure
- Package `mul_accum_pkg`:
  - state enum {IDLE, ACC, DONE}
  - `DATA_W` default
  - `SAT_MAX`=16'sh7FFF, `SAT_MIN`=16'sh8000
- Sub-module `sat_add`: combinational DATA_W signed saturating adder with outputs sum and `sat`. It is reusable by the ALU add path.
- `mul_accum` contains the FSM, count register, acc register and sticky flag.

## Test plan
- Sum with bubbles: `len`=3; products 100, 200, −50 with one idle cycle between each -> `res`=250, `res_ovf`=0; `res_valid` rises exactly one cycle after the third accept.
- Positive saturation: `len`=2; products 30000, 10000 -> `res`=32767, `res_ovf`=1.
- Negative saturation: `len`=2; products −30000, −10000 -> `res`=−32768, `res_ovf`=1.
- Product overflow passthrough: `len`=2; products 5 with `prod_ovf`=1, then 7 -> `res`=12, `res_ovf`=1.
- Zero length and output backpressure:
  - `len`=0 -> `res_valid` the next cycle, `res`=0.
  - Then hold `res_ready`=0 for 5 cycles while pulsing `start` and `prod_valid`: `res` stays stable, `prod_ready`=0, no new run starts.
  - Release `res_ready` -> IDLE.
- Reset mid-run:
  - `len`=3; assert `rst` after the first accept -> next cycle all outputs at reset values.
  - Then `start` with `len`=1 and product 9 -> `res`=9, `res_ovf`=0.
